// File: rtl/bec_pkg.sv
// Shared definitions for the GF(2^163) sequencer: opcodes, register indices,
// instruction field positions, FSM state encoding and an instruction legality check.
package bec_pkg;

  localparam int unsigned INSTR_W = 12;

  // Instruction field positions: op[11:9], dst[8:6], srca[5:3], srcb[2:0]
  localparam int unsigned OP_MSB   = 11;
  localparam int unsigned OP_LSB   = 9;
  localparam int unsigned DST_MSB  = 8;
  localparam int unsigned DST_LSB  = 6;
  localparam int unsigned SRCA_MSB = 5;
  localparam int unsigned SRCA_LSB = 3;
  localparam int unsigned SRCB_MSB = 2;
  localparam int unsigned SRCB_LSB = 0;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;  // GF(2) addition, i.e. XOR
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_SQR  = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;

  localparam logic [2:0] REG_A       = 3'd0;
  localparam logic [2:0] REG_B       = 3'd1;
  localparam logic [2:0] REG_C       = 3'd2;
  localparam logic [2:0] REG_D       = 3'd3;
  localparam logic [2:0] REG_E       = 3'd4;
  localparam logic [2:0] REG_F       = 3'd5;
  localparam logic [2:0] REG_H       = 3'd6;
  localparam logic [2:0] REG_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StFin,
    StErr
  } state_e;

  // HALT is always legal; index 7 is only illegal in fields the opcode actually reads.
  function automatic logic instr_legal(input logic [INSTR_W-1:0] instr);
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] srca;
    logic [2:0] srcb;
    op   = instr[OP_MSB:OP_LSB];
    dst  = instr[DST_MSB:DST_LSB];
    srca = instr[SRCA_MSB:SRCA_LSB];
    srcb = instr[SRCB_MSB:SRCB_LSB];
    case (op)
      OP_HALT:        instr_legal = 1'b1;
      OP_ADD, OP_MUL: instr_legal = (dst != REG_ILLEGAL) && (srca != REG_ILLEGAL) &&
                                    (srcb != REG_ILLEGAL);
      OP_SQR, OP_MOV: instr_legal = (dst != REG_ILLEGAL) && (srca != REG_ILLEGAL);
      default:        instr_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bec_prog_mem.sv
// Program store: DEPTH x 12-bit register file, synchronous write, combinational read.
// Deliberately has no reset; contents are undefined until written.
module bec_prog_mem
  import bec_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [3:0]         waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [3:0]         raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Write port; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port, out-of-range addresses read as HALT
  always_comb begin
    rdata = '0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem_q[raddr];
    end
  end

endmodule

// File: rtl/bec_seq_ctrl.sv
// Microcode sequencer for a GF(2^163) datapath: fetches 12-bit words from
// bec_prog_mem, issues them to the ALU and waits for completion.
// Optional feature: define BEC_SEQ_TIMEOUT_EN to add a WAIT watchdog that
// drops into ERR after TIMEOUT cycles without alu_done.
module bec_seq_ctrl
  import bec_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [11:0] prog_data,
  input  logic        start,
  input  logic        abort,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_dst,
  output logic [2:0]  alu_srca,
  output logic [2:0]  alu_srcb,
  input  logic        alu_done,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  pc
);

  localparam logic [3:0] LastPc = 4'(PROG_DEPTH - 1);

  state_e             state_q;
  logic [3:0]         pc_q;
  logic               busy_q, done_q, err_q, alu_start_q;
  logic [2:0]         op_q, dst_q, srca_q, srcb_q;
  logic [INSTR_W-1:0] instr;
  logic               mem_we;

`ifdef BEC_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);
  logic [TmoW-1:0] tmo_cnt_q;
`endif

  // Program may only change while no run is in flight
  assign mem_we = prog_we && ((state_q == StIdle) || (state_q == StFin) || (state_q == StErr));

  bec_prog_mem #(
    .DEPTH (PROG_DEPTH)
  ) u_prog_mem (
    .clk   (wb_clk_i),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (instr)
  );

  // Sequencer FSM with registered status and issue outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
      op_q        <= '0;
      dst_q       <= '0;
      srca_q      <= '0;
      srcb_q      <= '0;
`ifdef BEC_SEQ_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else if (abort) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alu_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      alu_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        StFetch: begin
          if (instr[OP_MSB:OP_LSB] == OP_HALT) begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (!instr_legal(instr)) begin
            state_q <= StErr;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            state_q     <= StIssue;
            alu_start_q <= 1'b1;
            op_q        <= instr[OP_MSB:OP_LSB];
            dst_q       <= instr[DST_MSB:DST_LSB];
            srca_q      <= instr[SRCA_MSB:SRCA_LSB];
            srcb_q      <= instr[SRCB_MSB:SRCB_LSB];
          end
        end
        StIssue: begin
          state_q <= StWait;
`ifdef BEC_SEQ_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (alu_done) begin
            if (pc_q == LastPc) begin
              // Last word completed: finish without wrapping pc
              state_q <= StFin;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
              pc_q    <= pc_q + 4'd1;
            end
          end
`ifdef BEC_SEQ_TIMEOUT_EN
          else if (tmo_cnt_q == TmoLast) begin
            state_q <= StErr;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        StFin: begin
          state_q <= StIdle;
        end
        StErr: begin
          if (start) begin
            state_q <= StFetch;
            pc_q    <= '0;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // An abort landing on the ISSUE cycle cancels the pulse at the pin
  assign alu_start = alu_start_q && !abort;
  assign alu_op    = op_q;
  assign alu_dst   = dst_q;
  assign alu_srca  = srca_q;
  assign alu_srcb  = srcb_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_bec_seq_ctrl.sv
// Scoreboard bench for bec_seq_ctrl: directed programs push expected issues
// ({pc, instruction word}) and done events; a monitor pops and compares them.
module tb_bec_seq_ctrl;

  localparam int unsigned TB_TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        resp_done = 1'b0;
  logic        man_done = 1'b0;
  logic        alu_done;
  logic        alu_start;
  logic [2:0]  alu_op, alu_dst, alu_srca, alu_srcb;
  logic        busy, done, err;
  logic [3:0]  pc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pend = 0;
  bit resp_en = 1'b0;

  logic [15:0] exp_issue[$];
  logic [3:0]  exp_done[$];
  int          issue_cyc[$];
  logic [11:0] bad_words[4];
  logic [11:0] word;

  assign alu_done = resp_done | man_done;

  bec_seq_ctrl #(
    .PROG_DEPTH (16),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .abort     (abort),
    .alu_start (alu_start),
    .alu_op    (alu_op),
    .alu_dst   (alu_dst),
    .alu_srca  (alu_srca),
    .alu_srcb  (alu_srcb),
    .alu_done  (alu_done),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .pc        (pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [11:0] d);
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick(1);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start_cyc = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
  endtask

  // Wait (bounded) until the scoreboard has drained, then let stray pulses show up
  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_issue.size() != 0 || exp_done.size() != 0) && n < 300) begin
      tick(1);
      n++;
    end
    chk({name, "_pending"}, 32'(exp_issue.size() + exp_done.size()), 32'd0);
    exp_issue.delete();
    exp_done.delete();
    tick(3);
  endtask

  // Monitor: compare every issue and every done pulse against the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (alu_start) begin
        issue_cyc.push_back(cyc);
        if (exp_issue.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue: got pc=%0d op=%0d dst=%0d required none", pc, alu_op,
                   alu_dst);
        end else begin
          chk("issue", {16'h0, pc, alu_op, alu_dst, alu_srca, alu_srcb},
              {16'h0, exp_issue.pop_front()});
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done at pc=%0d required none", pc);
        end else begin
          chk("done_pc", {28'h0, pc}, {28'h0, exp_done.pop_front()});
        end
      end
    end
  end

  // Datapath model: alu_done three cycles after each observed alu_start
  initial forever begin
    @(posedge clk);
    #1;
    resp_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) resp_done = 1'b1;
    end
    if (alu_start && resp_en) pend = 3;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done_err_start", {29'h0, done, err, alu_start}, 32'd0);
    chk("rst_pc_fields", {16'h0, pc, alu_op, alu_dst, alu_srca, alu_srcb}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // MUL 2,0,1 ; ADD 3,2,0 ; HALT with a 3-cycle datapath
    write_word(4'd0, 12'h481);
    write_word(4'd1, 12'h2D0);
    write_word(4'd2, 12'h000);
    resp_en = 1'b1;
    exp_issue.push_back({4'd0, 12'h481});
    exp_issue.push_back({4'd1, 12'h2D0});
    exp_done.push_back(4'd2);
    issue_cyc.delete();
    pulse_start();
    chk("busy_after_start", {31'h0, busy}, 32'd1);
    wait_drain("run3");
    chk("run3_issue_count", 32'(issue_cyc.size()), 32'd2);
    if (issue_cyc.size() == 2) begin
      chk("lat_start_to_issue", 32'(issue_cyc[0] - start_cyc), 32'd2);
      chk("lat_issue_to_issue", 32'(issue_cyc[1] - issue_cyc[0]), 32'd5);
    end
    chk("run3_busy_end", {31'h0, busy}, 32'd0);
    chk("fields_hold", {20'h0, alu_op, alu_dst, alu_srca, alu_srcb}, {20'h0, 12'h2D0});

    // Illegal words: ADD dst=7, op 101, MUL srcb=7, MOV srca=7
    resp_en = 1'b0;
    bad_words[0] = 12'h3C0;
    bad_words[1] = 12'hA00;
    bad_words[2] = 12'h407;
    bad_words[3] = 12'h838;
    for (int i = 0; i < 4; i++) begin
      write_word(4'd0, bad_words[i]);
      pulse_start();
      tick(2);
      chk("illegal_err", {31'h0, err}, 32'd1);
      chk("illegal_busy", {31'h0, busy}, 32'd0);
    end
    // Restart from ERR; word 0 is written in the same cycle as start
    write_word(4'd1, 12'h71F);  // SQR 4,3 with ignored srcb=7
    write_word(4'd2, 12'h000);
    resp_en = 1'b1;
    exp_issue.push_back({4'd0, 12'h850});  // MOV 1,2
    exp_issue.push_back({4'd1, 12'h71F});
    exp_done.push_back(4'd2);
    prog_we = 1'b1;
    prog_addr = 4'd0;
    prog_data = 12'h850;
    start = 1'b1;
    tick(1);
    prog_we = 1'b0;
    start = 1'b0;
    chk("err_cleared", {30'h0, err, busy}, 32'd1);
    wait_drain("recover");

    // Abort in WAIT, then a late alu_done
    resp_en = 1'b0;
    write_word(4'd0, 12'h240);
    write_word(4'd1, 12'h000);
    exp_issue.push_back({4'd0, 12'h240});
    pulse_start();
    tick(3);
    pulse_abort();
    chk("abort_busy_err", {30'h0, busy, err}, 32'd0);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(3);
    chk("abort_late_done_pc", {28'h0, pc}, 32'd0);
    chk("abort_late_done_busy", {31'h0, busy}, 32'd0);
    chk("abort_issue_seen", 32'(exp_issue.size()), 32'd0);
    // Abort coinciding with the issue cycle
    pulse_start();
    tick(1);
    abort = 1'b1;
    #1;
    chk("abort_masks_issue", {31'h0, alu_start}, 32'd0);
    tick(1);
    abort = 1'b0;
    chk("abort_issue_busy", {31'h0, busy}, 32'd0);
    tick(3);

    // Program writes while busy must be ignored
    write_word(4'd0, 12'h453);  // MUL 1,2,3
    write_word(4'd1, 12'h000);
    exp_issue.push_back({4'd0, 12'h453});
    pulse_start();
    tick(3);
    write_word(4'd0, 12'h240);
    write_word(4'd1, 12'h240);
    pulse_abort();
    tick(1);
    resp_en = 1'b1;
    exp_issue.push_back({4'd0, 12'h453});
    exp_done.push_back(4'd1);
    pulse_start();
    wait_drain("we_busy");

    // All 16 words non-HALT: no pc wrap, done at pc=15
    for (int i = 0; i < 16; i++) begin
      word = {3'b001, 3'(i % 7), 3'((i + 1) % 7), 3'((i + 2) % 7)};
      write_word(4'(i), word);
      exp_issue.push_back({4'(i), word});
    end
    exp_done.push_back(4'd15);
    pulse_start();
    wait_drain("full16");
    chk("full16_pc_end", {28'h0, pc}, 32'd15);

    // Reset asserted mid-WAIT takes effect immediately
    resp_en = 1'b0;
    write_word(4'd0, 12'h240);
    exp_issue.push_back({4'd0, 12'h240});
    pulse_start();
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {28'h0, busy, done, err, alu_start}, 32'd0);
    chk("midrst_pc_fields", {16'h0, pc, alu_op, alu_dst, alu_srca, alu_srcb}, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    man_done = 1'b1;
    tick(1);
    man_done = 1'b0;
    tick(2);
    chk("postrst_idle", {27'h0, pc, busy}, 32'd0);
    exp_issue.delete();

`ifdef BEC_SEQ_TIMEOUT_EN
    // Withheld alu_done: err exactly TIMEOUT cycles after entering WAIT
    exp_issue.push_back({4'd0, 12'h240});
    pulse_start();
    tick(TB_TIMEOUT + 1);
    chk("tmo_not_yet", {31'h0, err}, 32'd0);
    tick(1);
    chk("tmo_err", {30'h0, err, busy}, 32'd2);
    pulse_abort();
    tick(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
